// File: rtl/haraka_pkg.sv
// Shared types and constants for the Haraka-S sponge controller.
package haraka_pkg;

  localparam int RATE_W  = 256;
  localparam int STATE_W = 512;

  typedef logic [RATE_W-1:0]  rate_t;
  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PERM_LAUNCH,
    PERM_WAIT,
    SQUEEZE
  } sponge_st_e;

endpackage

// File: rtl/haraka_sponge_ctrl.sv
// Haraka-S sponge controller: absorb rate blocks, drive an external Haraka-512 core, squeeze digests.
// Optional permutation watchdog is built when HARAKA_PERM_TMO_EN is defined.
module haraka_sponge_ctrl
  import haraka_pkg::*;
#(
  parameter int NUM_SQZ = 1
`ifdef HARAKA_PERM_TMO_EN
  ,
  parameter int PERM_TMO = 64
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [RATE_W-1:0]  blk_data,
  input  logic               blk_last,
  output logic               perm_start,
  output logic [STATE_W-1:0] perm_din,
  input  logic [STATE_W-1:0] perm_dout,
  input  logic               perm_done,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [RATE_W-1:0]  dig_data,
  output logic               dig_last,
  output logic               busy,
  output logic               err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_SQZ - 1);

  sponge_st_e   fsm;
  state_t       state;
  logic         is_last;
  logic [3:0]   sqz_cnt;

`ifdef HARAKA_PERM_TMO_EN
  localparam int TMO_W = (PERM_TMO > 2) ? $clog2(PERM_TMO) : 2;
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  assign perm_din = state;
  assign dig_data = state[RATE_W-1:0];

  // Outputs are registered, so each transition also loads the outputs of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      state      <= '0;
      is_last    <= 1'b0;
      sqz_cnt    <= 4'd0;
      blk_ready  <= 1'b0;
      perm_start <= 1'b0;
      dig_valid  <= 1'b0;
      dig_last   <= 1'b0;
      busy       <= 1'b0;
`ifdef HARAKA_PERM_TMO_EN
      tmo_cnt    <= '0;
      err        <= 1'b0;
`endif
    end else begin
      perm_start <= 1'b0;
      case (fsm)
        IDLE: begin
          fsm       <= ABSORB;
          blk_ready <= 1'b1;
          busy      <= 1'b1;
        end

        ABSORB: begin
          if (blk_valid && blk_ready) begin
            state[RATE_W-1:0] <= state[RATE_W-1:0] ^ blk_data;
            is_last    <= blk_last;
            blk_ready  <= 1'b0;
            perm_start <= 1'b1;
            fsm        <= PERM_LAUNCH;
          end
        end

        PERM_LAUNCH: begin
          fsm <= PERM_WAIT;
`ifdef HARAKA_PERM_TMO_EN
          tmo_cnt <= '0;
`endif
        end

        PERM_WAIT: begin
          if (perm_done) begin
            state <= perm_dout;
`ifdef HARAKA_PERM_TMO_EN
            tmo_cnt <= '0;
`endif
            if (is_last) begin
              fsm       <= SQUEEZE;
              dig_valid <= 1'b1;
              dig_last  <= (sqz_cnt == LAST_IDX);
            end else begin
              fsm       <= ABSORB;
              blk_ready <= 1'b1;
            end
          end
`ifdef HARAKA_PERM_TMO_EN
          // err rises one cycle before the abort so it is visible on the final waiting cycle.
          else if (tmo_cnt == TMO_W'(PERM_TMO - 1)) begin
            err       <= 1'b1;
            state     <= '0;
            is_last   <= 1'b0;
            sqz_cnt   <= 4'd0;
            tmo_cnt   <= '0;
            blk_ready <= 1'b1;
            fsm       <= ABSORB;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_W'(PERM_TMO - 2)) begin
              err <= 1'b1;
            end
          end
`endif
        end

        SQUEEZE: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            if (dig_last) begin
              state     <= '0;
              sqz_cnt   <= 4'd0;
              is_last   <= 1'b0;
              blk_ready <= 1'b1;
              fsm       <= ABSORB;
            end else begin
              sqz_cnt    <= sqz_cnt + 4'd1;
              perm_start <= 1'b1;
              fsm        <= PERM_LAUNCH;
            end
          end
        end

        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haraka_sponge_ctrl.sv
// Directed self-checking bench for haraka_sponge_ctrl; a second instance runs with NUM_SQZ=3.
// The watchdog scenario is compiled only when HARAKA_PERM_TMO_EN is defined.
module tb_haraka_sponge_ctrl;
  import haraka_pkg::*;

  logic   clk, rst;
  logic   blk_valid, blk_ready, blk_last, perm_start, perm_done;
  logic   dig_valid, dig_ready, dig_last, busy, err;
  rate_t  blk_data, dig_data;
  state_t perm_din, perm_dout;

  logic   blk_valid3, blk_ready3, blk_last3, perm_start3, perm_done3;
  logic   dig_valid3, dig_ready3, dig_last3, busy3, err3;
  rate_t  blk_data3, dig_data3;
  state_t perm_din3, perm_dout3;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int starts3 = 0;

  haraka_sponge_ctrl #(
    .NUM_SQZ(1)
`ifdef HARAKA_PERM_TMO_EN
    , .PERM_TMO(8)
`endif
  ) u_dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .perm_start(perm_start), .perm_din(perm_din), .perm_dout(perm_dout), .perm_done(perm_done),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_last(dig_last),
    .busy(busy), .err(err)
  );

  haraka_sponge_ctrl #(
    .NUM_SQZ(3)
`ifdef HARAKA_PERM_TMO_EN
    , .PERM_TMO(8)
`endif
  ) u_dut3 (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid3), .blk_ready(blk_ready3), .blk_data(blk_data3), .blk_last(blk_last3),
    .perm_start(perm_start3), .perm_din(perm_din3), .perm_dout(perm_dout3), .perm_done(perm_done3),
    .dig_valid(dig_valid3), .dig_ready(dig_ready3), .dig_data(dig_data3), .dig_last(dig_last3),
    .busy(busy3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (perm_start)  starts++;
    if (perm_start3) starts3++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block and return in the cycle after the handshake (PERM_LAUNCH).
  task automatic send_block(input rate_t d, input logic last);
    int n = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = last;
    while (blk_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (blk_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL blk_ready_wait: blk_ready=%b after %0d cycles, required 1", blk_ready, n);
    end
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  // Called in PERM_LAUNCH; waits extra cycles in PERM_WAIT, then returns the permuted state.
  task automatic finish_perm(input state_t dout, input int wait_cyc);
    tick();
    repeat (wait_cyc) tick();
    perm_done = 1'b1;
    perm_dout = dout;
    tick();
    perm_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({blk_ready, perm_start, dig_valid, dig_last, busy, err} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, required 000000",
               {blk_ready, perm_start, dig_valid, dig_last, busy, err});
    end
    checks++;
    if (perm_din !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: perm_din=%h, required 0", perm_din);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (blk_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_to_absorb: blk_ready=%b busy=%b, required 1 1", blk_ready, busy);
    end
  endtask

  task automatic test_single_block();
    int s0 = starts;
    send_block(256'h1, 1'b1);
    checks++;
    if (perm_start !== 1'b1 || perm_din !== 512'h1) begin
      errors++;
      $display("[TB] FAIL single_launch: perm_start=%b perm_din=%h, required 1 and 1", perm_start, perm_din);
    end
    // A done arriving in PERM_LAUNCH must be ignored.
    perm_done = 1'b1;
    perm_dout = {64{8'hEE}};
    tick();
    perm_done = 1'b0;
    checks++;
    if (perm_start !== 1'b0 || perm_din !== 512'h1) begin
      errors++;
      $display("[TB] FAIL single_launch_done_ignored: perm_start=%b perm_din=%h, required 0 and 1",
               perm_start, perm_din);
    end
    tick();
    perm_done = 1'b1;
    perm_dout = {64{8'hA5}};
    tick();
    perm_done = 1'b0;
    checks++;
    if (dig_valid !== 1'b1 || dig_last !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_squeeze_flags: dig_valid=%b dig_last=%b blk_ready=%b, required 1 1 0",
               dig_valid, dig_last, blk_ready);
    end
    checks++;
    if (dig_data !== {32{8'hA5}}) begin
      errors++;
      $display("[TB] FAIL single_digest: dig_data=%h, required a5..a5", dig_data);
    end
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    checks++;
    if (dig_valid !== 1'b0 || blk_ready !== 1'b1 || perm_din !== '0) begin
      errors++;
      $display("[TB] FAIL single_done: dig_valid=%b blk_ready=%b perm_din=%h, required 0 1 0",
               dig_valid, blk_ready, perm_din);
    end
    checks++;
    if (starts - s0 !== 1) begin
      errors++;
      $display("[TB] FAIL single_start_count: got %0d pulses, required 1", starts - s0);
    end
  endtask

  // Leaves the DUT in SQUEEZE holding the digest of the three-block message.
  task automatic test_multi_block();
    int s0 = starts;
    rate_t  blks [3];
    state_t perms [3];
    state_t exp_din [3];
    blks[0] = {32{8'h11}};
    blks[1] = {32{8'h22}};
    blks[2] = {32{8'h33}};
    perms[0] = {{32{8'hC3}}, {32{8'h0F}}};
    perms[1] = {{32{8'h5A}}, {32{8'h3C}}};
    perms[2] = {{32{8'h99}}, {32{8'h77}}};
    exp_din[0] = {256'h0, {32{8'h11}}};
    exp_din[1] = {{32{8'hC3}}, {32{8'h2D}}};
    exp_din[2] = {{32{8'h5A}}, {32{8'h0F}}};
    for (int i = 0; i < 3; i++) begin
      send_block(blks[i], (i == 2));
      checks++;
      if (perm_start !== 1'b1 || perm_din !== exp_din[i]) begin
        errors++;
        $display("[TB] FAIL multi_din%0d: perm_start=%b perm_din=%h, required 1 and %h",
                 i, perm_start, perm_din, exp_din[i]);
      end
      finish_perm(perms[i], i + 1);
      checks++;
      if (i < 2) begin
        if (blk_ready !== 1'b1 || dig_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL multi_reabsorb%0d: blk_ready=%b dig_valid=%b, required 1 0",
                   i, blk_ready, dig_valid);
        end
      end else begin
        if (dig_valid !== 1'b1 || dig_last !== 1'b1 || dig_data !== {32{8'h77}}) begin
          errors++;
          $display("[TB] FAIL multi_digest: dig_valid=%b dig_last=%b dig_data=%h, required 1 1 77..77",
                   dig_valid, dig_last, dig_data);
        end
      end
    end
    checks++;
    if (starts - s0 !== 3) begin
      errors++;
      $display("[TB] FAIL multi_start_count: got %0d pulses, required 3", starts - s0);
    end
  endtask

  task automatic test_back_pressure();
    dig_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dig_valid !== 1'b1 || dig_data !== {32{8'h77}} || blk_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: dig_valid=%b blk_ready=%b dig_data=%h, required 1 0 77..77",
                 i, dig_valid, blk_ready, dig_data);
      end
      if (i == 4) begin
        perm_done = 1'b1;
        perm_dout = '1;
      end
      tick();
      perm_done = 1'b0;
    end
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    checks++;
    if (dig_valid !== 1'b0 || blk_ready !== 1'b1 || perm_din !== '0) begin
      errors++;
      $display("[TB] FAIL hold_release: dig_valid=%b blk_ready=%b perm_din=%h, required 0 1 0",
               dig_valid, blk_ready, perm_din);
    end
  endtask

  task automatic test_multi_squeeze();
    int s0 = starts3;
    int n = 0;
    state_t q [3];
    rate_t  exp_dig;
    q[0] = {{32{8'h01}}, {32{8'h10}}};
    q[1] = {{32{8'h02}}, {32{8'h20}}};
    q[2] = {{32{8'h03}}, {32{8'h30}}};
    blk_valid3 = 1'b1;
    blk_data3  = 256'h5;
    blk_last3  = 1'b1;
    while (blk_ready3 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    blk_valid3 = 1'b0;
    blk_last3  = 1'b0;
    checks++;
    if (perm_start3 !== 1'b1 || perm_din3 !== 512'h5) begin
      errors++;
      $display("[TB] FAIL sqz3_launch: perm_start=%b perm_din=%h, required 1 and 5", perm_start3, perm_din3);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        checks++;
        if (perm_start3 !== 1'b1 || perm_din3 !== q[i-1]) begin
          errors++;
          $display("[TB] FAIL sqz3_relaunch%0d: perm_start=%b perm_din=%h, required 1 and %h",
                   i, perm_start3, perm_din3, q[i-1]);
        end
      end
      tick();
      tick();
      perm_done3 = 1'b1;
      perm_dout3 = q[i];
      tick();
      perm_done3 = 1'b0;
      exp_dig = q[i][RATE_W-1:0];
      checks++;
      if (dig_valid3 !== 1'b1 || dig_last3 !== (i == 2) || dig_data3 !== exp_dig) begin
        errors++;
        $display("[TB] FAIL sqz3_digest%0d: dig_valid=%b dig_last=%b dig_data=%h, required 1 %b %h",
                 i, dig_valid3, dig_last3, dig_data3, (i == 2), exp_dig);
      end
      dig_ready3 = 1'b1;
      tick();
      dig_ready3 = 1'b0;
      checks++;
      if (dig_valid3 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sqz3_handshake%0d: dig_valid=%b, required 0", i, dig_valid3);
      end
    end
    checks++;
    if (blk_ready3 !== 1'b1 || starts3 - s0 !== 3) begin
      errors++;
      $display("[TB] FAIL sqz3_end: blk_ready=%b pulses=%0d, required 1 and 3", blk_ready3, starts3 - s0);
    end
  endtask

  task automatic test_reset_midop();
    send_block({32{8'h44}}, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({blk_ready, perm_start, dig_valid, dig_last, busy, err} !== 6'b0 || perm_din !== '0) begin
      errors++;
      $display("[TB] FAIL midop_reset: outputs=%b perm_din=%h, required 000000 and 0",
               {blk_ready, perm_start, dig_valid, dig_last, busy, err}, perm_din);
    end
    tick();
    rst = 1'b0;
    perm_done = 1'b1;
    perm_dout = '1;
    tick();
    perm_done = 1'b0;
    checks++;
    if (perm_din !== '0 || blk_ready !== 1'b1 || dig_valid !== 1'b0 || perm_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_stray_done: perm_din=%h blk_ready=%b dig_valid=%b perm_start=%b, required 0 1 0 0",
               perm_din, blk_ready, dig_valid, perm_start);
    end
  endtask

`ifdef HARAKA_PERM_TMO_EN
  task automatic test_timeout();
    send_block({32{8'h66}}, 1'b1);
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_early: err=%b on wait cycle 1, required 0", err);
    end
    repeat (6) tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_cycle7: err=%b, required 0", err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || blk_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_cycle8: err=%b blk_ready=%b, required 1 0", err, blk_ready);
    end
    tick();
    checks++;
    if (err !== 1'b1 || blk_ready !== 1'b1 || perm_din !== '0) begin
      errors++;
      $display("[TB] FAIL tmo_abort: err=%b blk_ready=%b perm_din=%h, required 1 1 0", err, blk_ready, perm_din);
    end
    repeat (5) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tmo_sticky: err=%b, required 1", err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_clear: err=%b after reset, required 0", err);
    end
    tick();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    blk_valid  = 1'b0;  blk_data  = '0;  blk_last  = 1'b0;
    perm_done  = 1'b0;  perm_dout = '0;  dig_ready = 1'b0;
    blk_valid3 = 1'b0;  blk_data3 = '0;  blk_last3 = 1'b0;
    perm_done3 = 1'b0;  perm_dout3 = '0; dig_ready3 = 1'b0;

    test_reset();
    test_single_block();
    test_multi_block();
    test_back_pressure();
    test_multi_squeeze();
    test_reset_midop();
`ifdef HARAKA_PERM_TMO_EN
    test_timeout();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
